dispatch_credit_ctrl: RTL and testbench

//  Dispatch-stage scheduler that sits in front of dispatch_iq_regs.
//  - Steers a renamed pair (slot 0 older than slot 1) onto the ALU, MDU and LSU issue-queue write ports.
//  - Tracks free-entry credits per issue queue and raises the write enables only when entries exist.
//  - Splits a pair across two cycles when only the older slot fits, and stalls rename while the pair is held.

---
 rtl/dispatch_credit_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dispatch_credit_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_credit_ctrl.sv
// Steers a renamed pair onto ALU/MDU/LSU issue-queue ports using per-queue credits. Decisions are combinational (0 cycles).
// A pair that does not fully fit is split or held, and dispatch_stall holds rename. DISPATCH_PERF_CNT_EN adds the perf counters.
module dispatch_credit_ctrl #(
    parameter int ALU_DEPTH = 8,
    parameter int MDU_DEPTH = 4,
    parameter int LSU_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        inst_valid_0,
    input  logic        inst_valid_1,
    input  logic [1:0]  inst_type_0,
    input  logic [1:0]  inst_type_1,
    input  logic [1:0]  alu_release,
    input  logic        mdu_release,
    input  logic [1:0]  lsu_release,
    output logic        rs_alu_wen_0,
    output logic        rs_alu_wen_1,
    output logic        rs_mdu_wen_0,
    output logic        rs_lsu_wen_0,
    output logic        rs_lsu_wen_1,
    output logic        alu_src_0,
    output logic        lsu_src_0,
    output logic        mdu_src,
    output logic        dispatch_stall,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_disp_cnt
);
    localparam int AW = $clog2(ALU_DEPTH + 1);
    localparam int MW = $clog2(MDU_DEPTH + 1);
    localparam int LW = $clog2(LSU_DEPTH + 1);
    localparam logic [1:0] T_ALU = 2'b00;
    localparam logic [1:0] T_MDU = 2'b01;
    localparam logic [1:0] T_LSU = 2'b10;

    typedef enum logic {NORM, SPLIT} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] alu_cr_q, alu_cr_d;
    logic [MW-1:0] mdu_cr_q, mdu_cr_d;
    logic [LW-1:0] lsu_cr_q, lsu_cr_d;
    logic [AW+1:0] alu_sum;
    logic [MW+1:0] mdu_sum;
    logic [LW+1:0] lsu_sum;

    logic s0_alu, s0_mdu, s0_lsu, s1_alu, s1_mdu, s1_lsu;
    logic s0_fit, s1_fit, pair_fit;
    logic disp0, disp1;
    logic a0, a1, m0, m1, l0, l1;

    assign s0_alu = inst_valid_0 && (inst_type_0 == T_ALU);
    assign s0_mdu = inst_valid_0 && (inst_type_0 == T_MDU);
    assign s0_lsu = inst_valid_0 && (inst_type_0 == T_LSU);
    assign s1_alu = inst_valid_1 && (inst_type_1 == T_ALU);
    assign s1_mdu = inst_valid_1 && (inst_type_1 == T_MDU);
    assign s1_lsu = inst_valid_1 && (inst_type_1 == T_LSU);

    // Fit uses registered credits only; releases become usable next cycle.
    assign s0_fit = (!s0_alu || alu_cr_q != '0) && (!s0_mdu || mdu_cr_q != '0) && (!s0_lsu || lsu_cr_q != '0);
    assign s1_fit = (!s1_alu || alu_cr_q != '0) && (!s1_mdu || mdu_cr_q != '0) && (!s1_lsu || lsu_cr_q != '0);
    assign pair_fit = ((AW+2)'(s0_alu) + (AW+2)'(s1_alu) <= (AW+2)'(alu_cr_q))
                   && !(s0_mdu && s1_mdu)
                   && (!(s0_mdu || s1_mdu) || mdu_cr_q != '0)
                   && ((LW+2)'(s0_lsu) + (LW+2)'(s1_lsu) <= (LW+2)'(lsu_cr_q));

    always_comb begin
        state_d        = state_q;
        disp0          = 1'b0;
        disp1          = 1'b0;
        dispatch_stall = 1'b0;
        if (rst || flush) begin
            state_d = NORM;
        end else begin
            case (state_q)
                NORM: begin
                    if (pair_fit) begin
                        disp0 = 1'b1;
                        disp1 = 1'b1;
                    end else if (s0_fit) begin
                        disp0          = 1'b1;
                        dispatch_stall = 1'b1;
                        state_d        = SPLIT;
                    end else begin
                        dispatch_stall = 1'b1;
                    end
                end
                SPLIT: begin
                    if (s1_fit) begin
                        disp1   = 1'b1;
                        state_d = NORM;
                    end else begin
                        dispatch_stall = 1'b1;
                    end
                end
            endcase
        end
    end

    assign a0 = disp0 && s0_alu;
    assign a1 = disp1 && s1_alu;
    assign m0 = disp0 && s0_mdu;
    assign m1 = disp1 && s1_mdu;
    assign l0 = disp0 && s0_lsu;
    assign l1 = disp1 && s1_lsu;

    // Port 0 always carries the oldest write, so slot 1 lands there only when alone.
    assign rs_alu_wen_0 = a0 | a1;
    assign rs_alu_wen_1 = a0 & a1;
    assign alu_src_0    = a1 & ~a0;
    assign rs_mdu_wen_0 = m0 | m1;
    assign mdu_src      = m1 & ~m0;
    assign rs_lsu_wen_0 = l0 | l1;
    assign rs_lsu_wen_1 = l0 & l1;
    assign lsu_src_0    = l1 & ~l0;

    assign alu_sum = (AW+2)'(alu_cr_q) + (AW+2)'(alu_release) - (AW+2)'(a0) - (AW+2)'(a1);
    assign mdu_sum = (MW+2)'(mdu_cr_q) + (MW+2)'(mdu_release) - (MW+2)'(m0) - (MW+2)'(m1);
    assign lsu_sum = (LW+2)'(lsu_cr_q) + (LW+2)'(lsu_release) - (LW+2)'(l0) - (LW+2)'(l1);

    assign alu_cr_d = (flush || alu_sum > (AW+2)'(ALU_DEPTH)) ? AW'(ALU_DEPTH) : alu_sum[AW-1:0];
    assign mdu_cr_d = (flush || mdu_sum > (MW+2)'(MDU_DEPTH)) ? MW'(MDU_DEPTH) : mdu_sum[MW-1:0];
    assign lsu_cr_d = (flush || lsu_sum > (LW+2)'(LSU_DEPTH)) ? LW'(LSU_DEPTH) : lsu_sum[LW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NORM;
            alu_cr_q <= AW'(ALU_DEPTH);
            mdu_cr_q <= MW'(MDU_DEPTH);
            lsu_cr_q <= LW'(LSU_DEPTH);
        end else begin
            state_q  <= state_d;
            alu_cr_q <= alu_cr_d;
            mdu_cr_q <= mdu_cr_d;
            lsu_cr_q <= lsu_cr_d;
            if (!flush) begin
                assert (alu_sum <= (AW+2)'(ALU_DEPTH));
                assert (mdu_sum <= (MW+2)'(MDU_DEPTH));
                assert (lsu_sum <= (LW+2)'(LSU_DEPTH));
            end
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] stall_cyc_q, stall_cyc_d, disp_cnt_q, disp_cnt_d;
    logic [1:0]  wen_cnt;

    assign wen_cnt = 2'(rs_alu_wen_0) + 2'(rs_alu_wen_1) + 2'(rs_mdu_wen_0) + 2'(rs_lsu_wen_0) + 2'(rs_lsu_wen_1);
    assign stall_cyc_d = stall_cyc_q + 32'(dispatch_stall);
    assign disp_cnt_d  = disp_cnt_q + 32'(wen_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cyc_q <= '0;
            disp_cnt_q  <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            disp_cnt_q  <= disp_cnt_d;
        end
    end

    assign perf_stall_cyc = rst ? '0 : stall_cyc_q;
    assign perf_disp_cnt  = rst ? '0 : disp_cnt_q;
`else
    assign perf_stall_cyc = '0;
    assign perf_disp_cnt  = '0;
`endif
endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Bench for dispatch_credit_ctrl: directed scenarios with hand-derived vectors, then randomized traffic against a queue-count model.
module tb_dispatch_credit_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, inst_valid_0, inst_valid_1, mdu_release;
    logic [1:0]  inst_type_0, inst_type_1, alu_release, lsu_release;
    logic        rs_alu_wen_0, rs_alu_wen_1, rs_mdu_wen_0, rs_lsu_wen_0, rs_lsu_wen_1;
    logic        alu_src_0, lsu_src_0, mdu_src, dispatch_stall;
    logic [31:0] perf_stall_cyc, perf_disp_cnt;

    dispatch_credit_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inst_valid_0(inst_valid_0), .inst_valid_1(inst_valid_1),
        .inst_type_0(inst_type_0), .inst_type_1(inst_type_1),
        .alu_release(alu_release), .mdu_release(mdu_release), .lsu_release(lsu_release),
        .rs_alu_wen_0(rs_alu_wen_0), .rs_alu_wen_1(rs_alu_wen_1), .rs_mdu_wen_0(rs_mdu_wen_0),
        .rs_lsu_wen_0(rs_lsu_wen_0), .rs_lsu_wen_1(rs_lsu_wen_1),
        .alu_src_0(alu_src_0), .lsu_src_0(lsu_src_0), .mdu_src(mdu_src),
        .dispatch_stall(dispatch_stall),
        .perf_stall_cyc(perf_stall_cyc), .perf_disp_cnt(perf_disp_cnt)
    );

    localparam logic [1:0] ALU = 2'b00, MDU = 2'b01, LSU = 2'b10, NON = 2'b11;

    int checks = 0;
    int errors = 0;

    // Reference model: free entries per queue and whether slot 1 is still owed.
    int          m_cr[3];
    int          m_depth[3] = '{8, 4, 8};
    bit          m_split = 1'b0;
    bit          m_stall = 1'b0;
    int          m_ps = 0, m_pd = 0;
    logic [8:0]  exp_v, obs_v;
    logic [31:0] exp_ps, exp_pd;

    typedef struct {
        logic       f;
        logic       v0;
        logic [1:0] t0;
        logic       v1;
        logic [1:0] t1;
        logic [1:0] ar;
        logic       mr;
        logic [1:0] lr;
        logic [8:0] exp;
    } row_t;

    function automatic int qidx(input logic v, input logic [1:0] t);
        if (!v || t == NON) return -1;
        return int'(t);
    endfunction

    function automatic bit fits(input int na, input int nm, input int nl);
        return (na <= m_cr[0]) && (nm <= 1) && (nm <= m_cr[1]) && (nl <= m_cr[2]);
    endfunction

    // One clock: drive inputs after the edge, predict, sample outputs on the falling edge.
    task automatic cyc(input logic r, input logic f, input logic v0, input logic [1:0] t0,
                       input logic v1, input logic [1:0] t1, input logic [1:0] ar,
                       input logic mr, input logic [1:0] lr);
        int q0, q1, n[3], rel[3], tot;
        bit d0, d1, st;
        @(posedge clk);
        #1;
        rst = r; flush = f; inst_valid_0 = v0; inst_type_0 = t0; inst_valid_1 = v1; inst_type_1 = t1;
        alu_release = ar; mdu_release = mr; lsu_release = lr;
        q0 = qidx(v0, t0);
        q1 = qidx(v1, t1);
        rel[0] = int'(ar); rel[1] = int'(mr); rel[2] = int'(lr);
        d0 = 1'b0; d1 = 1'b0; st = 1'b0;
`ifdef DISPATCH_PERF_CNT_EN
        exp_ps = r ? 32'd0 : 32'(m_ps);
        exp_pd = r ? 32'd0 : 32'(m_pd);
`else
        exp_ps = 32'd0;
        exp_pd = 32'd0;
`endif
        if (r || f) begin
            m_split = 1'b0;
            for (int q = 0; q < 3; q++) m_cr[q] = m_depth[q];
        end else begin
            if (m_split) begin
                d1 = fits(int'(q1 == 0), int'(q1 == 1), int'(q1 == 2));
                st = !d1;
                m_split = !d1;
            end else if (fits(int'(q0 == 0) + int'(q1 == 0), int'(q0 == 1) + int'(q1 == 1),
                              int'(q0 == 2) + int'(q1 == 2))) begin
                d0 = 1'b1; d1 = 1'b1;
            end else if (fits(int'(q0 == 0), int'(q0 == 1), int'(q0 == 2))) begin
                d0 = 1'b1; st = 1'b1; m_split = 1'b1;
            end else begin
                st = 1'b1;
            end
        end
        tot = 0;
        for (int q = 0; q < 3; q++) begin
            n[q] = int'(d0 && q0 == q) + int'(d1 && q1 == q);
            tot += n[q];
            if (!(r || f)) begin
                m_cr[q] = m_cr[q] - n[q] + rel[q];
                if (m_cr[q] > m_depth[q]) m_cr[q] = m_depth[q];
            end
        end
        exp_v = {n[0] >= 1, n[0] == 2, n[0] == 1 && d1 && q1 == 0,
                 n[1] >= 1, n[1] == 1 && d1 && q1 == 1,
                 n[2] >= 1, n[2] == 2, n[2] == 1 && d1 && q1 == 2, st};
        if (r) begin
            m_ps = 0; m_pd = 0;
        end else begin
            m_ps += int'(st); m_pd += tot;
        end
        m_stall = st;
        @(negedge clk);
        obs_v = {rs_alu_wen_0, rs_alu_wen_1, alu_src_0, rs_mdu_wen_0, mdu_src,
                 rs_lsu_wen_0, rs_lsu_wen_1, lsu_src_0, dispatch_stall};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b1, ALU, 1'b1, MDU, 2'd0, 1'b0, 2'd0);
            checks++;
            if (obs_v !== 9'b0) begin errors++; $display("FAIL reset_outputs got=%b want=%b", obs_v, 9'b0); end
            checks++;
            if ({perf_stall_cyc, perf_disp_cnt} !== 64'd0) begin
                errors++; $display("FAIL reset_perf got=%0d/%0d want=0/0", perf_stall_cyc, perf_disp_cnt);
            end
        end
    endtask

    task automatic test_pair_alu_lsu();
        cyc(1'b0, 1'b0, 1'b1, ALU, 1'b1, LSU, 2'd0, 1'b0, 2'd0);
        checks++;
        if (obs_v !== 9'b100001010) begin errors++; $display("FAIL alu_lsu_pair got=%b want=%b", obs_v, 9'b100001010); end
    endtask

    task automatic test_mdu_pair();
        row_t rows[2] = '{'{1'b0, 1'b1, MDU, 1'b1, MDU, 2'd0, 1'b0, 2'd0, 9'b000100001},
                          '{1'b0, 1'b1, MDU, 1'b1, MDU, 2'd0, 1'b0, 2'd0, 9'b000110000}};
        foreach (rows[i]) begin
            cyc(1'b0, rows[i].f, rows[i].v0, rows[i].t0, rows[i].v1, rows[i].t1, rows[i].ar, rows[i].mr, rows[i].lr);
            checks++;
            if (obs_v !== rows[i].exp) begin errors++; $display("FAIL mdu_pair[%0d] got=%b want=%b", i, obs_v, rows[i].exp); end
        end
    endtask

    task automatic test_perf();
        logic [31:0] want_s, want_d;
`ifdef DISPATCH_PERF_CNT_EN
        want_s = 32'd1; want_d = 32'd4;
`else
        want_s = 32'd0; want_d = 32'd0;
`endif
        cyc(1'b0, 1'b0, 1'b0, NON, 1'b0, NON, 2'd0, 1'b0, 2'd0);
        checks++;
        if (perf_stall_cyc !== want_s) begin errors++; $display("FAIL perf_stall got=%0d want=%0d", perf_stall_cyc, want_s); end
        checks++;
        if (perf_disp_cnt !== want_d) begin errors++; $display("FAIL perf_disp got=%0d want=%0d", perf_disp_cnt, want_d); end
    endtask

    task automatic test_mdu_drain();
        row_t rows[5] = '{'{1'b0, 1'b1, MDU, 1'b1, NON, 2'd0, 1'b0, 2'd0, 9'b000100000},
                          '{1'b0, 1'b1, MDU, 1'b1, NON, 2'd0, 1'b0, 2'd0, 9'b000100000},
                          '{1'b0, 1'b1, MDU, 1'b1, NON, 2'd0, 1'b0, 2'd0, 9'b000000001},
                          '{1'b0, 1'b1, MDU, 1'b1, NON, 2'd0, 1'b1, 2'd0, 9'b000000001},
                          '{1'b0, 1'b1, MDU, 1'b1, NON, 2'd0, 1'b0, 2'd0, 9'b000100000}};
        foreach (rows[i]) begin
            cyc(1'b0, rows[i].f, rows[i].v0, rows[i].t0, rows[i].v1, rows[i].t1, rows[i].ar, rows[i].mr, rows[i].lr);
            checks++;
            if (obs_v !== rows[i].exp) begin errors++; $display("FAIL mdu_drain[%0d] got=%b want=%b", i, obs_v, rows[i].exp); end
        end
    endtask

    task automatic test_alu_split();
        row_t rows[7] = '{'{1'b0, 1'b1, ALU, 1'b1, ALU, 2'd0, 1'b0, 2'd0, 9'b110000000},
                          '{1'b0, 1'b1, ALU, 1'b1, ALU, 2'd0, 1'b0, 2'd0, 9'b110000000},
                          '{1'b0, 1'b1, ALU, 1'b1, ALU, 2'd0, 1'b0, 2'd0, 9'b110000000},
                          '{1'b0, 1'b1, ALU, 1'b1, ALU, 2'd0, 1'b0, 2'd0, 9'b100000001},
                          '{1'b0, 1'b1, ALU, 1'b1, ALU, 2'd0, 1'b0, 2'd0, 9'b000000001},
                          '{1'b0, 1'b1, ALU, 1'b1, ALU, 2'd1, 1'b0, 2'd0, 9'b000000001},
                          '{1'b0, 1'b1, ALU, 1'b1, ALU, 2'd0, 1'b0, 2'd0, 9'b101000000}};
        foreach (rows[i]) begin
            cyc(1'b0, rows[i].f, rows[i].v0, rows[i].t0, rows[i].v1, rows[i].t1, rows[i].ar, rows[i].mr, rows[i].lr);
            checks++;
            if (obs_v !== rows[i].exp) begin errors++; $display("FAIL alu_split[%0d] got=%b want=%b", i, obs_v, rows[i].exp); end
        end
    endtask

    task automatic test_alu_starve();
        row_t rows[4] = '{'{1'b0, 1'b1, ALU, 1'b1, NON, 2'd0, 1'b0, 2'd0, 9'b000000001},
                          '{1'b0, 1'b1, ALU, 1'b1, NON, 2'd2, 1'b0, 2'd0, 9'b000000001},
                          '{1'b0, 1'b1, ALU, 1'b1, NON, 2'd0, 1'b0, 2'd0, 9'b100000000},
                          '{1'b0, 1'b1, ALU, 1'b1, ALU, 2'd0, 1'b0, 2'd0, 9'b100000001}};
        foreach (rows[i]) begin
            cyc(1'b0, rows[i].f, rows[i].v0, rows[i].t0, rows[i].v1, rows[i].t1, rows[i].ar, rows[i].mr, rows[i].lr);
            checks++;
            if (obs_v !== rows[i].exp) begin errors++; $display("FAIL alu_starve[%0d] got=%b want=%b", i, obs_v, rows[i].exp); end
        end
    endtask

    task automatic test_flush_split();
        row_t rows[13] = '{'{1'b1, 1'b1, ALU, 1'b1, ALU, 2'd2, 1'b0, 2'd0, 9'b000000000},
                           '{1'b0, 1'b1, ALU, 1'b1, ALU, 2'd0, 1'b0, 2'd0, 9'b110000000},
                           '{1'b0, 1'b1, LSU, 1'b1, LSU, 2'd0, 1'b0, 2'd0, 9'b000001100},
                           '{1'b0, 1'b1, LSU, 1'b1, LSU, 2'd0, 1'b0, 2'd0, 9'b000001100},
                           '{1'b0, 1'b1, LSU, 1'b1, LSU, 2'd0, 1'b0, 2'd0, 9'b000001100},
                           '{1'b0, 1'b1, LSU, 1'b1, LSU, 2'd0, 1'b0, 2'd0, 9'b000001100},
                           '{1'b0, 1'b1, LSU, 1'b1, LSU, 2'd0, 1'b0, 2'd0, 9'b000000001},
                           '{1'b0, 1'b1, MDU, 1'b1, NON, 2'd0, 1'b0, 2'd0, 9'b000100000},
                           '{1'b0, 1'b1, MDU, 1'b1, NON, 2'd0, 1'b0, 2'd0, 9'b000100000},
                           '{1'b0, 1'b1, MDU, 1'b1, NON, 2'd0, 1'b0, 2'd0, 9'b000100000},
                           '{1'b0, 1'b1, MDU, 1'b1, NON, 2'd0, 1'b0, 2'd0, 9'b000100000},
                           '{1'b0, 1'b1, MDU, 1'b1, NON, 2'd0, 1'b0, 2'd0, 9'b000000001},
                           '{1'b0, 1'b0, NON, 1'b1, LSU, 2'd0, 1'b0, 2'd0, 9'b000000001}};
        foreach (rows[i]) begin
            cyc(1'b0, rows[i].f, rows[i].v0, rows[i].t0, rows[i].v1, rows[i].t1, rows[i].ar, rows[i].mr, rows[i].lr);
            checks++;
            if (obs_v !== rows[i].exp) begin errors++; $display("FAIL flush_split[%0d] got=%b want=%b", i, obs_v, rows[i].exp); end
        end
    endtask

    task automatic test_random();
        logic       v0, v1, r, f, mr;
        logic [1:0] t0, t1, ar, lr;
        int         lim;
        v0 = inst_valid_0; v1 = inst_valid_1; t0 = inst_type_0; t1 = inst_type_1;
        for (int i = 0; i < 2000; i++) begin
            // Rename re-presents the same pair while the previous cycle stalled.
            if (!m_stall) begin
                v0 = 1'($urandom_range(0, 3) != 0);
                v1 = 1'($urandom_range(0, 3) != 0);
                t0 = 2'($urandom_range(0, 3));
                t1 = 2'($urandom_range(0, 3));
            end
            r = 1'($urandom_range(0, 199) == 0);
            f = 1'($urandom_range(0, 29) == 0);
            lim = m_depth[0] - m_cr[0]; if (lim > 2) lim = 2;
            ar = 2'($urandom_range(0, lim));
            lim = m_depth[1] - m_cr[1]; if (lim > 1) lim = 1;
            mr = 1'($urandom_range(0, lim));
            lim = m_depth[2] - m_cr[2]; if (lim > 2) lim = 2;
            lr = 2'($urandom_range(0, lim));
            cyc(r, f, v0, t0, v1, t1, ar, mr, lr);
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL random_ports[%0d] got=%b want=%b", i, obs_v, exp_v); end
            checks++;
            if ({perf_stall_cyc, perf_disp_cnt} !== {exp_ps, exp_pd}) begin
                errors++;
                $display("FAIL random_perf[%0d] got=%0d/%0d want=%0d/%0d", i, perf_stall_cyc, perf_disp_cnt, exp_ps, exp_pd);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; inst_valid_0 = 1'b0; inst_valid_1 = 1'b0;
        inst_type_0 = NON; inst_type_1 = NON; alu_release = 2'd0; mdu_release = 1'b0; lsu_release = 2'd0;
        for (int q = 0; q < 3; q++) m_cr[q] = m_depth[q];
        test_reset();
        test_pair_alu_lsu();
        test_mdu_pair();
        test_perf();
        test_mdu_drain();
        test_alu_split();
        test_alu_starve();
        test_flush_split();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
